// File: rtl/mux2_rr_arbiter_if.sv
// Handshake and data bundle between two requesters and the shared 2:1 mux arbiter.
// The master side drives requests and data; the arbiter (slave) returns grants, select and muxed data.
interface mux2_rr_arbiter_if #(
   parameter int WIDTH = 8
);
   logic             req0;
   logic             req1;
   logic [WIDTH-1:0] i0;
   logic [WIDTH-1:0] i1;
   logic             gnt0;
   logic             gnt1;
   logic             s;
   logic [WIDTH-1:0] y;
   logic             y_valid;

   modport master (
      output req0, req1, i0, i1,
      input  gnt0, gnt1, s, y, y_valid
   );

   modport slave (
      input  req0, req1, i0, i1,
      output gnt0, gnt1, s, y, y_valid
   );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux between two requesters, with a bounded
// grant hold under contention and a registered output word plus valid flag.
module mux2_rr_arbiter #(
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   mux2_rr_arbiter_if.slave     bus
);

   localparam int                CNT_W     = $clog2(MAX_HOLD + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic             last_q, last_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             y_valid_q, y_valid_d;
   logic             xfer;

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      last_d     = last_q;

      unique case (state_q)
         IDLE: begin
            hold_cnt_d = '0;
            // On a tie the requester that was not served last wins.
            if (bus.req0 && bus.req1) begin
               state_d = last_q ? GRANT0 : GRANT1;
            end else if (bus.req0) begin
               state_d = GRANT0;
            end else if (bus.req1) begin
               state_d = GRANT1;
            end
         end
         GRANT0: begin
            if (!bus.req0) begin
               state_d = bus.req1 ? GRANT1 : IDLE;
            end else if (bus.req1) begin
               if (hold_cnt_q == HOLD_LAST) begin
                  state_d = GRANT1;
               end else begin
                  hold_cnt_d = hold_cnt_q + CNT_W'(1);
               end
            end
         end
         GRANT1: begin
            if (!bus.req1) begin
               state_d = bus.req0 ? GRANT0 : IDLE;
            end else if (bus.req0) begin
               if (hold_cnt_q == HOLD_LAST) begin
                  state_d = GRANT0;
               end else begin
                  hold_cnt_d = hold_cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Any change of owner starts a fresh hold window and records who was served.
      if (state_d != state_q) begin
         hold_cnt_d = '0;
         if (state_d == GRANT0) last_d = 1'b0;
         if (state_d == GRANT1) last_d = 1'b1;
      end
   end

   always_comb begin
      xfer      = ((state_q == GRANT0) && bus.req0) || ((state_q == GRANT1) && bus.req1);
      y_d       = y_q;
      y_valid_d = xfer;
      if (xfer) begin
         y_d = (state_q == GRANT1) ? bus.i1 : bus.i0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         hold_cnt_q <= '0;
         last_q     <= 1'b1;
         y_q        <= '0;
         y_valid_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         last_q     <= last_d;
         y_q        <= y_d;
         y_valid_q  <= y_valid_d;
      end
   end

   assign bus.gnt0    = (state_q == GRANT0);
   assign bus.gnt1    = (state_q == GRANT1);
   assign bus.s       = (state_q == GRANT1);
   assign bus.y       = y_q;
   assign bus.y_valid = y_valid_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: a MAX_HOLD=4 and a MAX_HOLD=1 instance share the same stimulus;
// vectors, hand sequences and random traffic are compared with an ownership/streak model.
module tb_mux2_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, req1;
   logic [7:0] i0, i1;

   int checks   = 0;
   int failures = 0;

   mux2_rr_arbiter_if #(.WIDTH(8)) bus0 ();
   mux2_rr_arbiter_if #(.WIDTH(8)) bus1 ();

   assign bus0.req0 = req0;
   assign bus0.req1 = req1;
   assign bus0.i0   = i0;
   assign bus0.i1   = i1;
   assign bus1.req0 = req0;
   assign bus1.req1 = req1;
   assign bus1.i0   = i0;
   assign bus1.i1   = i1;

   mux2_rr_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   mux2_rr_arbiter #(.WIDTH(8), .MAX_HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   always #5 clk = ~clk;

   // Reference model: who owns the mux, how many granted cycles the owner has
   // used while the other side waited, who was served last, and the output word.
   int         maxh  [2] = '{4, 1};
   int         owner [2] = '{-1, -1};
   int         streak[2] = '{0, 0};
   int         lastw [2] = '{1, 1};
   logic [7:0] ey    [2] = '{8'h00, 8'h00};
   logic       ev    [2] = '{1'b0, 1'b0};

   task automatic model_step(input int k);
      logic r[2];
      logic [7:0] d[2];
      int nxt;
      r[0] = req0; r[1] = req1;
      d[0] = i0;   d[1] = i1;
      if (rst) begin
         owner[k] = -1; streak[k] = 0; lastw[k] = 1; ey[k] = 8'h00; ev[k] = 1'b0;
         return;
      end
      ev[k] = (owner[k] >= 0) && r[owner[k]];
      if (ev[k]) ey[k] = d[owner[k]];
      if (owner[k] < 0) begin
         if (r[0] && r[1]) nxt = 1 - lastw[k];
         else if (r[0])    nxt = 0;
         else if (r[1])    nxt = 1;
         else              nxt = -1;
      end else if (!r[owner[k]]) begin
         nxt = r[1 - owner[k]] ? 1 - owner[k] : -1;
      end else if (r[1 - owner[k]]) begin
         streak[k]++;
         nxt = (streak[k] >= maxh[k]) ? 1 - owner[k] : owner[k];
      end else begin
         nxt = owner[k];
      end
      if (nxt != owner[k]) begin
         streak[k] = 0;
         if (nxt >= 0) lastw[k] = nxt;
      end
      owner[k] = nxt;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      for (int k = 0; k < 2; k++) model_step(k);
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input int k);
      logic g0, g1, ss, vv;
      logic [7:0] yy;
      if (k == 0) begin
         g0 = bus0.gnt0; g1 = bus0.gnt1; ss = bus0.s; yy = bus0.y; vv = bus0.y_valid;
      end else begin
         g0 = bus1.gnt0; g1 = bus1.gnt1; ss = bus1.s; yy = bus1.y; vv = bus1.y_valid;
      end
      chk($sformatf("m%0d_gnt0", k), 32'(g0), 32'(owner[k] == 0));
      chk($sformatf("m%0d_gnt1", k), 32'(g1), 32'(owner[k] == 1));
      chk($sformatf("m%0d_s", k), 32'(ss), 32'(owner[k] == 1));
      chk($sformatf("m%0d_y", k), 32'(yy), 32'(ey[k]));
      chk($sformatf("m%0d_y_valid", k), 32'(vv), 32'(ev[k]));
      chk($sformatf("m%0d_excl", k), 32'(g0 & g1), 32'd0);
   endtask

   typedef struct {
      logic       rst, r0, r1;
      logic [7:0] a, b;
      logic       g0, g1, s;
      logic [7:0] y;
      logic       v;
   } vec_t;

   vec_t vecs[$];

   initial begin
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; i0 = 8'h00; i1 = 8'h00;

      // Expected outputs of the MAX_HOLD=4 instance after the edge that samples each row.
      vecs.push_back(vec_t'{1, 1, 1, 8'h11, 8'h22, 0, 0, 0, 8'h00, 0}); // reset with both requesting
      vecs.push_back(vec_t'{1, 1, 1, 8'h11, 8'h22, 0, 0, 0, 8'h00, 0});
      vecs.push_back(vec_t'{0, 1, 1, 8'h11, 8'h22, 1, 0, 0, 8'h00, 0}); // tie after reset goes to 0
      vecs.push_back(vec_t'{0, 1, 1, 8'h11, 8'h22, 1, 0, 0, 8'h11, 1});
      vecs.push_back(vec_t'{0, 1, 1, 8'h11, 8'h22, 1, 0, 0, 8'h11, 1});
      vecs.push_back(vec_t'{0, 1, 1, 8'h11, 8'h22, 1, 0, 0, 8'h11, 1});
      vecs.push_back(vec_t'{0, 1, 1, 8'h11, 8'h22, 0, 1, 1, 8'h11, 1}); // forced switch after 4
      vecs.push_back(vec_t'{0, 1, 1, 8'h11, 8'h22, 0, 1, 1, 8'h22, 1});
      vecs.push_back(vec_t'{0, 1, 1, 8'h11, 8'h22, 0, 1, 1, 8'h22, 1});
      vecs.push_back(vec_t'{0, 1, 1, 8'h11, 8'h22, 0, 1, 1, 8'h22, 1});
      vecs.push_back(vec_t'{0, 1, 1, 8'h11, 8'h22, 1, 0, 0, 8'h22, 1});
      vecs.push_back(vec_t'{0, 1, 1, 8'h11, 8'h22, 1, 0, 0, 8'h11, 1});
      vecs.push_back(vec_t'{0, 1, 0, 8'hA5, 8'h22, 1, 0, 0, 8'hA5, 1}); // lone requester holds
      vecs.push_back(vec_t'{0, 1, 0, 8'hA5, 8'h22, 1, 0, 0, 8'hA5, 1});
      vecs.push_back(vec_t'{0, 1, 0, 8'hA5, 8'h22, 1, 0, 0, 8'hA5, 1});
      vecs.push_back(vec_t'{0, 1, 0, 8'hA5, 8'h22, 1, 0, 0, 8'hA5, 1});
      vecs.push_back(vec_t'{0, 0, 0, 8'hA5, 8'h22, 0, 0, 0, 8'hA5, 0}); // release to idle
      vecs.push_back(vec_t'{0, 0, 0, 8'hA5, 8'h22, 0, 0, 0, 8'hA5, 0});
      vecs.push_back(vec_t'{0, 1, 1, 8'h11, 8'h22, 0, 1, 1, 8'hA5, 0}); // tie after serving 0
      vecs.push_back(vec_t'{0, 0, 0, 8'h11, 8'h22, 0, 0, 0, 8'hA5, 0}); // grant with req low
      vecs.push_back(vec_t'{0, 1, 1, 8'h11, 8'h22, 1, 0, 0, 8'hA5, 0}); // tie after serving 1
      vecs.push_back(vec_t'{0, 0, 1, 8'h11, 8'h22, 0, 1, 1, 8'hA5, 0}); // early release, no bubble
      vecs.push_back(vec_t'{0, 0, 1, 8'h11, 8'h22, 0, 1, 1, 8'h22, 1});
      vecs.push_back(vec_t'{1, 0, 1, 8'h11, 8'h22, 0, 0, 0, 8'h00, 0}); // reset mid-grant
      vecs.push_back(vec_t'{0, 0, 0, 8'h11, 8'h22, 0, 0, 0, 8'h00, 0});

      @(negedge clk);
      for (int n = 0; n < vecs.size(); n++) begin
         rst = vecs[n].rst; req0 = vecs[n].r0; req1 = vecs[n].r1;
         i0 = vecs[n].a; i1 = vecs[n].b;
         tick();
         chk($sformatf("v%0d_gnt0", n), 32'(bus0.gnt0), 32'(vecs[n].g0));
         chk($sformatf("v%0d_gnt1", n), 32'(bus0.gnt1), 32'(vecs[n].g1));
         chk($sformatf("v%0d_s", n), 32'(bus0.s), 32'(vecs[n].s));
         chk($sformatf("v%0d_y", n), 32'(bus0.y), 32'(vecs[n].y));
         chk($sformatf("v%0d_y_valid", n), 32'(bus0.y_valid), 32'(vecs[n].v));
         chk($sformatf("v%0d_excl", n), 32'(bus0.gnt0 & bus0.gnt1), 32'd0);
         check_model(1);
      end

      // MAX_HOLD=1: continuous contention alternates the grant every cycle.
      rst = 1'b1; req0 = 1'b1; req1 = 1'b1; i0 = 8'h11; i1 = 8'h22;
      tick();
      rst = 1'b0;
      for (int j = 0; j < 6; j++) begin
         tick();
         chk($sformatf("alt%0d_gnt0", j), 32'(bus1.gnt0), 32'(j % 2 == 0));
         chk($sformatf("alt%0d_gnt1", j), 32'(bus1.gnt1), 32'(j % 2 == 1));
         chk($sformatf("alt%0d_y_valid", j), 32'(bus1.y_valid), 32'(j != 0));
         chk($sformatf("alt%0d_y", j), 32'(bus1.y),
             (j == 0) ? 32'h00 : ((j % 2 == 1) ? 32'h11 : 32'h22));
         check_model(0);
      end

      // Random traffic against the model on both instances.
      for (int j = 0; j < 400; j++) begin
         rst  = ($urandom_range(0, 49) == 0);
         req0 = ($urandom_range(0, 3) != 0);
         req1 = ($urandom_range(0, 3) != 0);
         i0   = 8'($urandom);
         i1   = 8'($urandom);
         tick();
         check_model(0);
         check_model(1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
